// File: rtl/axis_buffer_writer.sv
// Stream-to-SRAM writer: places each accepted AXI4-Stream beat at a linear address from a latched base.
// Optional in-stream ID consistency check is enabled by defining AXIS_BUFFER_WRITER_ID_CHECK_EN.
module axis_buffer_writer #(
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  beat_count,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beats_written,
    output logic                  err_early_last,
    output logic                  err_missing_last,
    output logic                  err_id,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                r_state;
    state_t                w_nextState;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beatsWritten;
    logic [ADDR_WIDTH-1:0] r_nextAddr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic                  r_errEarly;
    logic                  r_errMissing;
    logic                  w_accept;
    logic                  w_finalBeat;
    logic                  w_startIdle;

    // Accept is derived from the state register so in_ready never depends on in_valid.
    assign w_accept    = in_valid && ((r_state == RUN) || (r_state == DRAIN));
    assign w_finalBeat = (r_beatsWritten == (r_len - LEN_ONE));
    assign w_startIdle = start && (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = (beat_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) begin
                    if (in_last) begin
                        w_nextState = DONE;
                    end else if (w_finalBeat) begin
                        w_nextState = DRAIN;
                    end
                end
            end
            DRAIN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && in_last) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Write port is fully registered; the final write lands in the same cycle as done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len          <= '0;
            r_beatsWritten <= '0;
            r_nextAddr     <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_we           <= 1'b0;
            r_errEarly     <= 1'b0;
            r_errMissing   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_startIdle) begin
                r_beatsWritten <= '0;
                r_errEarly     <= 1'b0;
                r_errMissing   <= 1'b0;
                if (beat_count != '0) begin
                    r_len      <= beat_count;
                    r_nextAddr <= base_addr;
                end
            end else if (w_accept && (r_state == RUN)) begin
                r_we           <= 1'b1;
                r_addr         <= r_nextAddr;
                r_wdata        <= in_data;
                r_nextAddr     <= r_nextAddr + ADDR_ONE;
                r_beatsWritten <= r_beatsWritten + LEN_ONE;
                if (in_last && !w_finalBeat) begin
                    r_errEarly <= 1'b1;
                end
                if (!in_last && w_finalBeat) begin
                    r_errMissing <= 1'b1;
                end
            end
        end
    end

`ifdef AXIS_BUFFER_WRITER_ID_CHECK_EN
    logic [ID_WIDTH-1:0] r_id;
    logic                r_errId;
    logic                w_unused;

    assign w_unused = ^in_user;

    // The first beat of a transfer (always in RUN with nothing written yet) sets the reference ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= '0;
            r_errId <= 1'b0;
        end else if (w_startIdle) begin
            r_errId <= 1'b0;
        end else if (w_accept) begin
            if ((r_state == RUN) && (r_beatsWritten == '0)) begin
                r_id <= in_id;
            end else if (in_id != r_id) begin
                r_errId <= 1'b1;
            end
        end
    end

    assign err_id = r_errId;
`else
    logic w_unused;

    assign w_unused = ^{in_user, in_id};
    assign err_id   = 1'b0;
`endif

    assign beats_written    = r_beatsWritten;
    assign err_early_last   = r_errEarly;
    assign err_missing_last = r_errMissing;
    assign mem_we           = r_we;
    assign mem_addr         = r_addr;
    assign mem_wdata        = r_wdata;

endmodule

// File: tb/tb_axis_buffer_writer.sv
// Bench for axis_buffer_writer: transaction-level scoreboard model checked every cycle,
// plus literal expectations per directed scenario.
module tb_axis_buffer_writer;

    localparam int DW = 128;
    localparam int UW = 4;
    localparam int IW = 4;
    localparam int AW = 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [UW-1:0] in_user;
    logic [IW-1:0] in_id;
    logic          in_valid;
    logic          in_ready;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] beat_count;
    logic          busy;
    logic          done;
    logic [LW-1:0] beats_written;
    logic          err_early_last;
    logic          err_missing_last;
    logic          err_id;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    axis_buffer_writer #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_last(in_last), .in_user(in_user), .in_id(in_id),
        .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .base_addr(base_addr), .beat_count(beat_count),
        .busy(busy), .done(done), .beats_written(beats_written),
        .err_early_last(err_early_last), .err_missing_last(err_missing_last), .err_id(err_id),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard model: a transfer is "open" while beats may be accepted; mLeft counts beats still owed to SRAM.
    logic          mOpen;
    int            mLeft;
    logic [AW-1:0] mBase;
    logic [AW-1:0] mK;
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    logic          expDone;
    logic [LW-1:0] expBw;
    logic          expEarly;
    logic          expMiss;
    logic          expIdErr;
    logic [IW-1:0] mId;
    logic          mIdSet;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mOpen <= 0; mLeft <= 0; mBase <= '0; mK <= '0;
            expWe <= 0; expAddr <= '0; expData <= '0; expDone <= 0; expBw <= '0;
            expEarly <= 0; expMiss <= 0; expIdErr <= 0; mId <= '0; mIdSet <= 0;
        end else begin
            expWe   <= 0;
            expDone <= 0;
            if (!mOpen && !expDone) begin
                if (start) begin
                    expEarly <= 0; expMiss <= 0; expIdErr <= 0; mIdSet <= 0;
                    expBw <= '0; mK <= '0; mBase <= base_addr; mLeft <= int'(beat_count);
                    if (beat_count == 0) expDone <= 1;
                    else mOpen <= 1;
                end
            end else if (mOpen && in_valid) begin
                if (mLeft > 0) begin
                    expWe   <= 1;
                    expAddr <= mBase + mK;
                    expData <= in_data;
                    expBw   <= expBw + 1'b1;
                    mK      <= mK + 1'b1;
                    mLeft   <= mLeft - 1;
                    if (mLeft == 1 && !in_last) expMiss <= 1;
                    if (mLeft > 1 && in_last) expEarly <= 1;
                end
                if (in_last) begin
                    mOpen   <= 0;
                    expDone <= 1;
                end
`ifdef AXIS_BUFFER_WRITER_ID_CHECK_EN
                if (!mIdSet) begin
                    mId <= in_id; mIdSet <= 1;
                end else if (in_id != mId) begin
                    expIdErr <= 1;
                end
`endif
            end
        end
    end

    logic [AW-1:0] wrAddr[$];
    logic [DW-1:0] wrData[$];
    int            wrCycle[$];
    int            cycleNo = 0;
    int            doneCount = 0;
    int            doneCycle = -1;
    int            readyCount = 0;

    // Every falling edge: DUT against the model, and a log of writes for the literal checks.
    always @(negedge clk) begin
        cycleNo++;
        checkOutput("in_ready", in_ready, mOpen);
        checkOutput("busy", busy, mOpen | expDone);
        checkOutput("done", done, expDone);
        checkOutput("mem_we", mem_we, expWe);
        checkOutput("beats_written", beats_written, expBw);
        checkOutput("err_early_last", err_early_last, expEarly);
        checkOutput("err_missing_last", err_missing_last, expMiss);
        checkOutput("err_id", err_id, expIdErr);
        if (expWe) begin
            checkOutput("mem_addr", mem_addr, expAddr);
            checkOutput("mem_wdata", mem_wdata, expData);
        end
        if (mem_we) begin
            wrAddr.push_back(mem_addr);
            wrData.push_back(mem_wdata);
            wrCycle.push_back(cycleNo);
        end
        if (done) begin
            doneCount++;
            doneCycle = cycleNo;
        end
        if (in_ready) readyCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit l, input logic [IW-1:0] id);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        in_id    = id;
        tick();
    endtask

    task automatic startXfer(input logic [AW-1:0] base, input logic [LW-1:0] count);
        start      = 1'b1;
        base_addr  = base;
        beat_count = count;
        in_valid   = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        doneCount  = 0;
        doneCycle  = -1;
        readyCount = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; base_addr = '0; beat_count = '0;
        in_valid = 0; in_data = '0; in_last = 0; in_user = '0; in_id = '0;
        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ready", in_ready, 0);
        checkOutput("reset_we", mem_we, 0);
        checkOutput("reset_bw", beats_written, 0);
        #10 rst_n = 1'b1;
        tick();

        // Nominal: four beats from 0x0100, last on the fourth
        clearLog();
        startXfer(16'h0100, 16'd4);
        for (int k = 0; k < 4; k++) applyStimulus(1, 128'hD0 + k, k == 3, 4'h1);
        idleCycles(3);
        checkOutput("nom_nwrites", wrAddr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("nom_addr", wrAddr[i], 16'h0100 + i);
            checkOutput("nom_data", wrData[i], 128'hD0 + i);
            checkOutput("nom_consecutive", wrCycle[i], wrCycle[0] + i);
        end
        checkOutput("nom_done_with_last_write", doneCycle, wrCycle[3]);
        checkOutput("nom_done_count", doneCount, 1);
        checkOutput("nom_bw", beats_written, 4);
        checkOutput("nom_errs", {err_early_last, err_missing_last, err_id}, 0);

        // Early last: expect 8, last arrives on the third beat
        clearLog();
        startXfer(16'h0200, 16'd8);
        for (int k = 0; k < 3; k++) applyStimulus(1, 128'hE0 + k, k == 2, 4'h1);
        idleCycles(3);
        checkOutput("early_nwrites", wrAddr.size(), 3);
        checkOutput("early_flag", err_early_last, 1);
        checkOutput("early_bw", beats_written, 3);
        checkOutput("early_done_with_last_write", doneCycle, wrCycle[2]);

        // Missing last: expect 2, packet is 4 beats long
        clearLog();
        startXfer(16'h0300, 16'd2);
        for (int k = 0; k < 4; k++) applyStimulus(1, 128'hB0 + k, k == 3, 4'h1);
        idleCycles(3);
        checkOutput("miss_nwrites", wrAddr.size(), 2);
        checkOutput("miss_data1", wrData[1], 128'hB1);
        checkOutput("miss_flag", err_missing_last, 1);
        checkOutput("miss_early_clear", err_early_last, 0);
        checkOutput("miss_bw", beats_written, 2);
        checkOutput("miss_done_count", doneCount, 1);

        // Address wrap with valid toggling 1,0,1,0,1
        clearLog();
        startXfer(16'hFFFE, 16'd3);
        applyStimulus(1, 128'hA0, 0, 4'h1);
        applyStimulus(0, 128'hFF, 0, 4'h1);
        applyStimulus(1, 128'hA1, 0, 4'h1);
        applyStimulus(0, 128'hFF, 0, 4'h1);
        applyStimulus(1, 128'hA2, 1, 4'h1);
        idleCycles(3);
        checkOutput("wrap_nwrites", wrAddr.size(), 3);
        checkOutput("wrap_addr0", wrAddr[0], 16'hFFFE);
        checkOutput("wrap_addr1", wrAddr[1], 16'hFFFF);
        checkOutput("wrap_addr2", wrAddr[2], 16'h0000);
        checkOutput("wrap_stall_gap", wrCycle[1] - wrCycle[0], 2);

        // Zero-length transfer: straight to done, never ready
        clearLog();
        startXfer(16'h0055, 16'd0);
        checkOutput("zero_done_now", done, 1);
        checkOutput("zero_busy_now", busy, 1);
        idleCycles(3);
        checkOutput("zero_ready_never", readyCount, 0);
        checkOutput("zero_done_count", doneCount, 1);
        checkOutput("zero_bw", beats_written, 0);
        checkOutput("zero_miss_cleared", err_missing_last, 0);

        // start pulse mid-transfer is ignored
        clearLog();
        startXfer(16'h0400, 16'd4);
        applyStimulus(1, 128'hC0, 0, 4'h1);
        applyStimulus(1, 128'hC1, 0, 4'h1);
        start = 1; base_addr = 16'h0777; beat_count = 16'd1;
        applyStimulus(1, 128'hC2, 0, 4'h1);
        start = 0;
        applyStimulus(1, 128'hC3, 1, 4'h1);
        idleCycles(3);
        checkOutput("midstart_nwrites", wrAddr.size(), 4);
        checkOutput("midstart_addr2", wrAddr[2], 16'h0402);
        checkOutput("midstart_addr3", wrAddr[3], 16'h0403);
        checkOutput("midstart_errs", {err_early_last, err_missing_last}, 0);

        // ID consistency: IDs 2,2,5,2
        clearLog();
        startXfer(16'h0500, 16'd4);
        applyStimulus(1, 128'h10, 0, 4'h2);
        applyStimulus(1, 128'h11, 0, 4'h2);
        applyStimulus(1, 128'h12, 0, 4'h5);
        applyStimulus(1, 128'h13, 1, 4'h2);
        idleCycles(3);
        checkOutput("id_nwrites", wrAddr.size(), 4);
`ifdef AXIS_BUFFER_WRITER_ID_CHECK_EN
        checkOutput("id_flag", err_id, 1);
`else
        checkOutput("id_flag", err_id, 0);
`endif

        // Asynchronous reset while a write is pending
        clearLog();
        startXfer(16'h0600, 16'd4);
        applyStimulus(1, 128'h20, 0, 4'h1);
        applyStimulus(1, 128'h21, 0, 4'h1);
        checkOutput("rst_pending_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_we", mem_we, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_data", mem_wdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", in_ready, 0);
        checkOutput("rst_bw", beats_written, 0);
        in_valid = 0;
        #2 rst_n = 1'b1;
        idleCycles(3);
        checkOutput("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
